// File: rtl/scm_bist_pkg.sv
// Shared types and March C- element tables for the SCM register-file BIST.
package scm_bist_pkg;

  // March C- elements, in execution order
  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } march_elem_e;

  // Single memory operation kinds: write/read of the all-0 or all-1 background
  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    R0 = 2'd2,
    R1 = 2'd3
  } op_kind_e;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bist_state_e;

  // Number of operations per address in each element
  function automatic logic [1:0] elem_op_cnt(input march_elem_e e);
    case (e)
      E0, E5:  return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Operation idx (0 or 1) of element e
  function automatic op_kind_e elem_op(input march_elem_e e, input logic idx);
    case (e)
      E0:      return W0;
      E1:      return idx ? W1 : R0;
      E2:      return idx ? W0 : R1;
      E3:      return idx ? W1 : R0;
      E4:      return idx ? W0 : R1;
      E5:      return R0;
      default: return R0;
    endcase
  endfunction

  // Address direction of element e: 1 = descending
  function automatic logic elem_desc(input march_elem_e e);
    case (e)
      E3, E4:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // True for write operations
  function automatic logic op_is_write(input op_kind_e o);
    return (o == W0) || (o == W1);
  endfunction

  // Background bit written or expected by an operation
  function automatic logic op_bg(input op_kind_e o);
    return (o == W1) || (o == R1);
  endfunction

endpackage

// File: rtl/scm_bist_addr_gen.sv
// Up/down word address counter with load-to-start and terminal-count flag.
module scm_bist_addr_gen
  import scm_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec,       // current direction, 1 = descending
  input  logic                  step,      // advance one address in direction dec
  input  logic                  load,      // reload start address for next element
  input  logic                  load_dec,  // direction of the element being loaded
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last       // addr is the final address of the sweep
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MIN = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] addr_r;

  assign addr = addr_r;
  assign last = dec ? (addr_r == ADDR_MIN) : (addr_r == ADDR_MAX);

  // Address register: load has priority over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= ADDR_MIN;
    end else if (load) begin
      addr_r <= load_dec ? ADDR_MAX : ADDR_MIN;
    end else if (step) begin
      addr_r <= dec ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
    end
  end

endmodule

// File: rtl/scm_march_bist.sv
// March C- BIST controller for the 1R/1W standard-cell-memory test wrapper.
// A sequencer pointer always names the next op to drive; it rests on E0/w0/addr 0
// while idle so the first op reaches the pins the cycle after start.
module scm_march_bist
  import scm_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [7:0]            fail_cnt,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  input  logic [DATA_WIDTH-1:0] Q_T
);

  bist_state_e           state_r, state_s;
  march_elem_e           elem_r, elem_s;
  logic                  op_idx_r, op_idx_s;
  logic                  issued_all_r;
  op_kind_e              op_s;
  logic                  accept_s, issue_s, last_in_elem_s, final_op_s;
  logic                  addr_step_s, addr_load_s, load_dec_s, addr_last_s;
  logic [ADDR_WIDTH-1:0] addr_s;

  // Pin, status and compare-pipeline registers
  logic                  busy_r, done_r, fail_r, bist_r, csn_r, wen_r;
  logic [ADDR_WIDTH-1:0] fail_addr_r, a_r;
  logic [2:0]            fail_elem_r;
  logic [7:0]            fail_cnt_r;
  logic [DATA_WIDTH-1:0] d_r;
  logic                  rd_vld_r, rd_exp_r, cmp_vld_r, cmp_exp_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r, cmp_addr_r;
  march_elem_e           rd_elem_r, cmp_elem_r;
  logic                  mismatch_s;

  assign busy         = busy_r;
  assign done         = done_r;
  assign fail         = fail_r;
  assign fail_addr    = fail_addr_r;
  assign fail_element = fail_elem_r;
  assign fail_cnt     = fail_cnt_r;
  assign BIST         = bist_r;
  assign CSN_T        = csn_r;
  assign WEN_T        = wen_r;
  assign A_T          = a_r;
  assign D_T          = d_r;

  scm_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (elem_desc(elem_r)),
    .step     (addr_step_s),
    .load     (addr_load_s),
    .load_dec (load_dec_s),
    .addr     (addr_s),
    .last     (addr_last_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: RUN until every op is issued, one DRAIN cycle for the last compare
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = RUN; else state_s = IDLE;
      RUN:     if (issued_all_r) state_s = DRAIN; else state_s = RUN;
      DRAIN:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Op sequencer: decode the pointed-to op and compute the pointer advance
  always_comb begin
    accept_s       = (state_r == IDLE) && start;
    issue_s        = accept_s || ((state_r == RUN) && !issued_all_r);
    op_s           = elem_op(elem_r, op_idx_r);
    last_in_elem_s = (elem_op_cnt(elem_r) == 2'd1) || op_idx_r;
    final_op_s     = (elem_r == E5) && last_in_elem_s && addr_last_s;
    elem_s         = elem_r;
    op_idx_s       = op_idx_r;
    addr_step_s    = 1'b0;
    addr_load_s    = 1'b0;
    load_dec_s     = 1'b0;
    if (issue_s) begin
      if (!last_in_elem_s) begin
        op_idx_s = 1'b1;
      end else begin
        op_idx_s = 1'b0;
        if (!addr_last_s) begin
          addr_step_s = 1'b1;
        end else begin
          // after E5 the pointer wraps to E0 so it is ready for the next start
          elem_s      = (elem_r == E5) ? E0 : march_elem_e'(elem_r + 3'd1);
          addr_load_s = 1'b1;
          load_dec_s  = elem_desc(elem_s);
        end
      end
    end else begin
      op_idx_s = op_idx_r;
    end
  end

  // Sequencer pointer and end-of-issue flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_r       <= E0;
      op_idx_r     <= 1'b0;
      issued_all_r <= 1'b0;
    end else begin
      elem_r   <= elem_s;
      op_idx_r <= op_idx_s;
      if (issue_s && final_op_s) begin
        issued_all_r <= 1'b1;
      end else if (state_r == DRAIN) begin
        issued_all_r <= 1'b0;
      end
    end
  end

  // Memory pins: drive the issued op, otherwise deselect and hold A_T/D_T
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      bist_r <= 1'b0;
      csn_r  <= 1'b1;
      wen_r  <= 1'b1;
      a_r    <= {ADDR_WIDTH{1'b0}};
      d_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      bist_r <= (state_s != IDLE);
      if (issue_s) begin
        csn_r <= 1'b0;
        wen_r <= !op_is_write(op_s);
        a_r   <= addr_s;
        if (op_is_write(op_s)) begin
          d_r <= {DATA_WIDTH{op_bg(op_s)}};
        end
      end else begin
        csn_r <= 1'b1;
        wen_r <= 1'b1;
      end
    end
  end

  // Compare pipeline: the read context travels alongside the pins, then waits one
  // more cycle for Q_T
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_r   <= 1'b0;
      rd_exp_r   <= 1'b0;
      rd_addr_r  <= {ADDR_WIDTH{1'b0}};
      rd_elem_r  <= E0;
      cmp_vld_r  <= 1'b0;
      cmp_exp_r  <= 1'b0;
      cmp_addr_r <= {ADDR_WIDTH{1'b0}};
      cmp_elem_r <= E0;
    end else begin
      rd_vld_r   <= issue_s && !op_is_write(op_s);
      rd_exp_r   <= op_bg(op_s);
      rd_addr_r  <= addr_s;
      rd_elem_r  <= elem_r;
      cmp_vld_r  <= rd_vld_r;
      cmp_exp_r  <= rd_exp_r;
      cmp_addr_r <= rd_addr_r;
      cmp_elem_r <= rd_elem_r;
    end
  end

  assign mismatch_s = cmp_vld_r && (Q_T != {DATA_WIDTH{cmp_exp_r}});

  // Status: cleared on accepted start, sticky first-fail capture, saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_addr_r <= {ADDR_WIDTH{1'b0}};
      fail_elem_r <= 3'd0;
      fail_cnt_r  <= 8'd0;
    end else if (accept_s) begin
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_addr_r <= {ADDR_WIDTH{1'b0}};
      fail_elem_r <= 3'd0;
      fail_cnt_r  <= 8'd0;
    end else begin
      if (state_r == DRAIN) begin
        done_r <= 1'b1;
      end
      if (mismatch_s) begin
        if (fail_cnt_r != 8'hFF) begin
          fail_cnt_r <= fail_cnt_r + 8'd1;
        end
        if (!fail_r) begin
          fail_r      <= 1'b1;
          fail_addr_r <= cmp_addr_r;
          fail_elem_r <= cmp_elem_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_scm_march_bist.sv
// Self-checking bench for scm_march_bist: behavioural register-file wrapper with an
// optional stuck-at cell, and a March C- reference walk producing the expected op
// stream and final status.
module tb_scm_march_bist;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int N    = 1 << AW;
  localparam int NOPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail, bist, csn_t, wen_t;
  logic [AW-1:0] fail_addr, a_t;
  logic [2:0]    fail_element;
  logic [7:0]    fail_cnt;
  logic [DW-1:0] d_t, q_t;

  logic [DW-1:0] mem [N];
  bit            fault_en  = 1'b0;
  int            fault_addr = 0;
  int            fault_bit  = 0;
  bit            fault_val  = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit            we;
    int            addr;
    logic [DW-1:0] data;
  } op_t;
  op_t exp_q[$];

  // March C- from its textbook definition: op codes 0=w0 1=w1 2=r0 3=r1, -1=none
  int march_ops  [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
  bit march_desc [6]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  bit          m_fail;
  int          m_faddr, m_felem, m_fcnt;
  logic [DW-1:0] m_last_wd;

  always #5 clk = ~clk;

  scm_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_element (fail_element),
    .fail_cnt     (fail_cnt),
    .BIST         (bist),
    .CSN_T        (csn_t),
    .WEN_T        (wen_t),
    .A_T          (a_t),
    .D_T          (d_t),
    .Q_T          (q_t)
  );

  // Stuck-at cell applied on the read path of the faulty word
  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] m;
    m = '0;
    m[fault_bit] = 1'b1;
    if (!fault_en || a != fault_addr) return v;
    return fault_val ? (v | m) : (v & ~m);
  endfunction

  // Register-file wrapper: synchronous write, read data one cycle after the read
  always @(posedge clk) begin
    if (!csn_t) begin
      if (!wen_t) mem[a_t] <= d_t;
      else        q_t <= faulty(mem[a_t], int'(a_t));
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk the march over an ideal array with the fault: expected ops and status
  task automatic build_model();
    logic [DW-1:0] mm [N];
    logic [DW-1:0] data, got;
    int a, op;
    exp_q.delete();
    m_fail = 1'b0; m_faddr = 0; m_felem = 0; m_fcnt = 0; m_last_wd = '0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = march_desc[e] ? (N - 1 - i) : i;
        for (int j = 0; j < 2; j++) begin
          op = march_ops[e][j];
          if (op >= 0) begin
            data = (op % 2 == 1) ? '1 : '0;
            if (op < 2) begin
              mm[a] = data;
              m_last_wd = data;
              exp_q.push_back('{1'b1, a, data});
            end else begin
              exp_q.push_back('{1'b0, a, '0});
              got = faulty(mm[a], a);
              if (got != data) begin
                if (m_fcnt < 255) m_fcnt++;
                if (!m_fail) begin
                  m_fail = 1'b1; m_faddr = a; m_felem = e;
                end
              end
            end
          end
        end
      end
    end
  endtask

  // One run: start in the current cycle (or the next if align), optional extra start
  // pulse at busy_pulse, optional reset at rst_cyc (run abandoned there)
  task automatic run_test(input bit align, input int busy_pulse, input int rst_cyc);
    int nw, nr;
    op_t o;
    nw = 0; nr = 0;
    build_model();
    if (align) begin @(posedge clk); #1; end
    start = 1'b1;
    for (int cyc = 1; cyc <= NOPS + 2; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == busy_pulse);
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_eq("rst_mid_ctl", {busy, bist, csn_t, wen_t, done, fail, a_t, fail_addr, fail_element, fail_cnt},
                 {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 8'd0});
        check_eq("rst_mid_d", d_t, 64'd0);
        #2 rst_n = 1'b1;
        return;
      end
      if (!csn_t) begin
        if (!wen_t) nw++; else nr++;
      end
      if (cyc == 1)
        check_eq("clear_on_start", {done, fail, fail_cnt, fail_addr, fail_element}, 64'd0);
      if (cyc <= NOPS) begin
        o = exp_q[cyc-1];
        check_eq("op", {busy, bist, csn_t, wen_t, done, a_t, (wen_t ? {DW{1'b0}} : d_t)},
                 {1'b1, 1'b1, 1'b0, !o.we, 1'b0, AW'(o.addr), (o.we ? o.data : {DW{1'b0}})});
        if (cyc - 1 == 5 * N)     check_eq("e3_first_addr", a_t, 64'd31);
        if (cyc - 1 == 7 * N - 1) check_eq("e3_last_addr", a_t, 64'd0);
        if (cyc - 1 == 7 * N)     check_eq("e4_first_addr", a_t, 64'd31);
      end else if (cyc == NOPS + 1) begin
        check_eq("drain", {busy, bist, csn_t, wen_t, done, a_t, d_t},
                 {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, AW'(exp_q[NOPS-1].addr), m_last_wd});
      end else begin
        check_eq("end_ctl", {busy, bist, csn_t, wen_t, done}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        check_eq("fail", fail, m_fail);
        check_eq("fail_addr", fail_addr, m_faddr);
        check_eq("fail_element", fail_element, m_felem);
        check_eq("fail_cnt", fail_cnt, m_fcnt);
        check_eq("n_writes", nw, 5 * N);
        check_eq("n_reads", nr, 5 * N);
      end
    end
  endtask

  initial begin
    #12;
    check_eq("reset_ctl", {busy, bist, csn_t, wen_t, done, fail, a_t, fail_addr, fail_element, fail_cnt},
             {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 8'd0});
    check_eq("reset_d", d_t, 64'd0);
    #1 rst_n = 1'b1;

    // clean run with an ignored start at cycle 100
    run_test(1'b1, 100, 0);

    // stuck-at-1 on bit 3 of word 7, started in the cycle done rises
    fault_en = 1'b1; fault_addr = 7; fault_bit = 3; fault_val = 1'b1;
    run_test(1'b0, 0, 0);
    check_eq("sa1_addr", fail_addr, 64'd7);
    check_eq("sa1_elem", fail_element, 64'd1);
    check_eq("sa1_cnt", fail_cnt, 64'd3);

    // fault-free run straight after the failing one
    fault_en = 1'b0;
    run_test(1'b0, 0, 0);

    // reset at cycle 150, then a full clean run
    run_test(1'b1, 0, 150);
    run_test(1'b1, 0, 0);

    // randomized faults, stray starts and one random reset
    for (int i = 0; i < 4; i++) begin
      fault_en   = 1'($urandom_range(0, 1));
      fault_addr = $urandom_range(0, N - 1);
      fault_bit  = $urandom_range(0, DW - 1);
      fault_val  = 1'($urandom_range(0, 1));
      run_test(1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? $urandom_range(2, NOPS + 1) : 0,
               (i == 2) ? $urandom_range(1, NOPS + 1) : 0);
    end
    fault_en = 1'b0;
    run_test(1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
